clken_nco_gen: RTL and testbench

- Parametrised, fully synchronous successor to the fixed-frequency clock generator.
- Derives NUM_CH independent fractional clock-enable streams from one reference clock using per-channel phase accumulators (NCOs).
- Rates are runtime-programmable through a small config port; a lock indicator reports settled operation.
- Sits at the top of the core; feeds CPU, timer and LCD clock-enables (e.g. 4.0 / 4.194528 / 16.046511 MHz equivalents) without extra PLL outputs.

---
 rtl/clken_nco_gen.sv | 109 ++++++++++
 tb/tb_clken_nco_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clken_nco_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators turn runtime-programmable
// increments into one-cycle enable pulses, with a lock flag. Macro CLKEN_NCO_TOGGLE_EN adds toggle outputs.
module clken_nco_gen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_WIDTH-1:0] INC_RESET = '0
) (
    input  logic                                          refclk,
    input  logic                                          rst,
    input  logic                                          cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [ACC_WIDTH-1:0]                          cfg_inc,
    input  logic                                          phase_rst,
    output logic [NUM_CH-1:0]                             ce,
    output logic [NUM_CH-1:0]                             clk_tgl,
    output logic                                          locked
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0][ACC_WIDTH-1:0] inc_q, inc_d;
    logic [NUM_CH-1:0]                ce_q, ce_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             locked_q, locked_d;
    logic                             cfg_valid;
    logic                             disturb;
    logic [ACC_WIDTH:0]               sum;

    // The config port is a single-cycle strobe with no back-pressure: every edge with cfg_we=1 and an
    // in-range cfg_ch is accepted; out-of-range writes are dropped with no side effects.
    always_comb begin
        cfg_valid = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
        disturb   = cfg_valid || phase_rst;
        acc_d     = acc_q;
        inc_d     = inc_q;
        ce_d      = '0;
        sum       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Accumulate with the increment in force before this edge; a new increment applies next edge.
            sum       = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i]  = sum[ACC_WIDTH-1:0];
            ce_d[i]   = sum[ACC_WIDTH];
            if (cfg_valid && (cfg_ch == CH_W'(i))) begin
                inc_d[i] = cfg_inc;
            end
        end
        if (phase_rst) begin
            acc_d = '0;
            ce_d  = '0;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        locked_d = 1'b0;
        if (disturb) begin
            cnt_d = '0;
        end else begin
            if (cnt_q < LOCK_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            locked_d = (cnt_d == LOCK_MAX);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_q    <= '0;
            inc_q    <= INC_RESET;
            ce_q     <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            ce_q     <= ce_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign ce     = ce_q;
    assign locked = locked_q;

`ifdef CLKEN_NCO_TOGGLE_EN
    logic [NUM_CH-1:0] tgl_q, tgl_d;

    always_comb begin
        tgl_d = phase_rst ? '0 : (tgl_q ^ ce_d);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            tgl_q <= '0;
        end else begin
            tgl_q <= tgl_d;
        end
    end

    assign clk_tgl = tgl_q;
`else
    assign clk_tgl = '0;
`endif

endmodule

// File: tb/tb_clken_nco_gen.sv
// Bench for clken_nco_gen: a per-cycle scoreboard of {clk_tgl, locked, ce} fed by a wide-total rate
// model, plus directed checks with hand-derived pulse positions, counts and lock timing.
module tb_clken_nco_gen;
    localparam int NUM_CH      = 3;
    localparam int ACC_WIDTH   = 32;
    localparam int LOCK_CYCLES = 1024;
    localparam logic [NUM_CH*ACC_WIDTH-1:0] TB_INC_RESET = {32'h0000_0000, 32'h0000_0000, 32'h4000_0000};
    localparam int W = 2 * NUM_CH + 1;

    // clock / reset block
    logic                 refclk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [1:0]           cfg_ch;
    logic [ACC_WIDTH-1:0] cfg_inc;
    logic                 phase_rst;
    logic [NUM_CH-1:0]    ce;
    logic [NUM_CH-1:0]    clk_tgl;
    logic                 locked;

    always #5 refclk = ~refclk;

    clken_nco_gen #(
        .NUM_CH(NUM_CH),
        .ACC_WIDTH(ACC_WIDTH),
        .LOCK_CYCLES(LOCK_CYCLES),
        .INC_RESET(TB_INC_RESET)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc),
        .phase_rst(phase_rst),
        .ce(ce),
        .clk_tgl(clk_tgl),
        .locked(locked)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rate model: each channel keeps an unwrapped 64-bit phase total; a pulse is a change in its upper word.
    logic [NUM_CH*ACC_WIDTH-1:0] inc_rst_v = TB_INC_RESET;
    logic [63:0]       m_tot [NUM_CH];
    logic [31:0]       m_inc [NUM_CH];
    logic [NUM_CH-1:0] m_ce;
    logic [NUM_CH-1:0] m_tgl;
    int                m_cnt;
    logic              m_locked;
    logic [W-1:0]      exp_q[$];

    task automatic model_edge();
        logic        hit;
        logic [63:0] prev;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_tot[i] = '0;
                m_inc[i] = inc_rst_v[i*32 +: 32];
            end
            m_ce     = '0;
            m_tgl    = '0;
            m_cnt    = 0;
            m_locked = 1'b0;
        end else begin
            hit = cfg_we && (int'(cfg_ch) < NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                prev     = m_tot[i];
                m_tot[i] = m_tot[i] + {32'h0, m_inc[i]};
                m_ce[i]  = (m_tot[i][63:32] != prev[63:32]);
            end
            if (phase_rst) begin
                for (int i = 0; i < NUM_CH; i++) m_tot[i] = '0;
                m_ce  = '0;
                m_tgl = '0;
            end else begin
`ifdef CLKEN_NCO_TOGGLE_EN
                m_tgl = m_tgl ^ m_ce;
`else
                m_tgl = '0;
`endif
            end
            if (hit) m_inc[int'(cfg_ch)] = cfg_inc;
            if (hit || phase_rst) begin
                m_cnt    = 0;
                m_locked = 1'b0;
            end else begin
                if (m_cnt < LOCK_CYCLES - 1) m_cnt++;
                m_locked = (m_cnt == LOCK_CYCLES - 1);
            end
        end
        exp_q.push_back({m_tgl, m_locked, m_ce});
    endtask

    // Monitor: the DUT presents {clk_tgl, locked, ce} every cycle; compare on the falling edge.
    always @(negedge refclk) begin
        logic [W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_out", {clk_tgl, locked, ce}, e);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] val, input logic prst);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = val;
        phase_rst = prst;
        tick();
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_inc   = '0;
        phase_rst = 1'b0;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 1100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int cnt, last, gmin, gmax, adj, n;
        logic prev;
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; phase_rst = 1'b0;
        repeat (3) tick();
        check("rst_ce", ce, 0);
        check("rst_locked", locked, 0);
        check("rst_tgl", clk_tgl, 0);

        // Reset increment 0x40000000 on ch0: first pulse on the 4th edge after release, then every 4th.
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("ce0_after_rst", ce[0], (k % 4) == 0);
            check("ce12_idle", ce[2:1], 0);
        end

        // ch1 = 0x55555555: k-th pulse lands on edge 3k+1 after the write, so edges 2..3001 hold 1000.
        cfg_write(2'd1, 32'h5555_5555, 1'b0);
        cnt = 0; last = 0; gmin = 99; gmax = 0;
        for (int k = 1; k <= 3001; k++) begin
            tick();
            if (k >= 2 && ce[1]) begin
                if (last != 0) begin
                    if (k - last < gmin) gmin = k - last;
                    if (k - last > gmax) gmax = k - last;
                end
                last = k;
                cnt++;
            end
        end
        check("ce1_count", cnt, 1000);
        check("ce1_gap_min_ge2", gmin >= 2, 1);
        check("ce1_gap_max_le3", gmax <= 3, 1);
        check("locked_after_run", locked, 1);

        // Rate switch on ch0 to 0x80000000: lock drops at the write edge, then a pulse every 2 cycles.
        cfg_write(2'd0, 32'h8000_0000, 1'b0);
        check("cfg_drops_lock", locked, 0);
        cnt = 0; adj = 0; prev = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k >= 3) begin
                if (ce[0]) cnt++;
                if (ce[0] && prev) adj++;
            end
            prev = ce[0];
        end
        check("ce0_fast_count", cnt, 10);
        check("ce0_fast_adjacent", adj, 0);
        wait_lock(n);
        check("relock_after_cfg", n, LOCK_CYCLES - 1 - 22);

        // ch0=0x40000000, ch2=0xFFFFFFFF, then ch1=0x80000000 written in the same cycle as phase_rst.
        cfg_write(2'd0, 32'h4000_0000, 1'b0);
        cfg_write(2'd2, 32'hFFFF_FFFF, 1'b0);
        cfg_write(2'd1, 32'h8000_0000, 1'b1);
        check("prst_ce", ce, 0);
        check("prst_locked", locked, 0);
        check("prst_tgl", clk_tgl, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("prst_ce0", ce[0], (k % 4) == 0);
            check("prst_ce1", ce[1], (k % 2) == 0);
            check("prst_ce2_max_inc", ce[2], k != 1);
        end
        wait_lock(n);
        check("relock_after_prst", n, LOCK_CYCLES - 1 - 8);

        // Out-of-range channel write: ignored, lock holds, rates unchanged.
        cfg_write(2'd3, 32'h0000_0000, 1'b0);
        check("oor_keeps_lock", locked, 1);
        cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (ce[0]) cnt++;
            check("oor_ce2", ce[2], 1);
        end
        check("oor_ce0_count", cnt, 2);

        // Mid-run reset: outputs clear on that edge, increments return to their reset values.
        rst = 1'b1;
        tick();
        check("midrst_ce", ce, 0);
        check("midrst_locked", locked, 0);
        check("midrst_tgl", clk_tgl, 0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("rerst_ce0", ce[0], (k % 4) == 0);
            check("rerst_ce12", ce[2:1], 0);
`ifdef CLKEN_NCO_TOGGLE_EN
            check("tgl0_square", clk_tgl[0], ((k / 4) % 2) == 1);
`else
            check("tgl0_tied", clk_tgl[0], 0);
`endif
        end

        @(negedge refclk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
